// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointing FE->BE queue: speculative reads, commit via deq, replay via roll, flush via clr.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module bp_be_fe_queue_ckpt #(
    parameter int els_p   = 8,
    parameter int width_p = 64,
    localparam int ptr_width_lp = $clog2(els_p)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    input  logic               deq_i,
    input  logic               roll_i,
    input  logic               clr_i,
    output logic               empty_o
);

    typedef logic [ptr_width_lp:0] ptr_t;

    ptr_t               wptr, rptr, cptr;
    logic [width_p-1:0] mem [els_p];
    logic               full, enq;

    // Read-but-uncommitted entries still hold their slot, so fullness is measured from cptr.
    assign full    = (wptr[ptr_width_lp-1:0] == cptr[ptr_width_lp-1:0])
                   && (wptr[ptr_width_lp] != cptr[ptr_width_lp]);
    assign ready_o = ~full & ~clr_i;
    assign enq     = v_i & ready_o;
    assign v_o     = (rptr != wptr) & ~roll_i & ~clr_i;
    assign data_o  = mem[rptr[ptr_width_lp-1:0]];
    assign empty_o = (cptr == wptr);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr <= '0;
            rptr <= '0;
            cptr <= '0;
        end else begin
            wptr <= wptr + ptr_t'(enq);
            if (clr_i) begin
                rptr <= wptr;
                cptr <= wptr;
            end else if (roll_i) begin
                rptr <= cptr;
            end else begin
                rptr <= rptr + ptr_t'(yumi_i);
                cptr <= cptr + ptr_t'(deq_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr[ptr_width_lp-1:0]] <= data_i;
    end

    // yumi/deq are don't-cares in cycles where clr or roll override them.
    a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(yumi_i && !v_o && !roll_i && !clr_i));
    a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(deq_i && (cptr == rptr) && !roll_i && !clr_i));
    a_roll_deq: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(roll_i && deq_i));
    a_ctrl_known: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !$isunknown({v_i, yumi_i, deq_i, roll_i, clr_i}));

endmodule
